// File: rtl/spi_sched_pkg.sv
// Shared definitions for the SPI transfer scheduler.
//   sched_state_t   : scheduler FSM state encoding
//   DEF_NUM_REQ     : default number of requesters
//   DEF_TIP_TIMEOUT : default cycles allowed from send strobe to tip rising
//   DIV_W / MODE_W  : widths of the per-requester divisor and mode fields
package spi_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        START    = 3'd2,
        WAIT_TIP = 3'd3,
        XFER     = 3'd4,
        DONE     = 3'd5
    } sched_state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_TIP_TIMEOUT = 15;
    localparam int DIV_W           = 12;
    localparam int MODE_W          = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner selection.
//   req   : request vector, one bit per requester
//   ptr   : index with highest priority this round
//   grant : one-hot winner (all-zero when nothing requests)
//   idx   : binary index of the winner (0 when nothing requests)
//   valid : at least one request is present
// The search starts at ptr and walks upward, wrapping from NUM_REQ-1 to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // cand_idx[k] is the requester examined k-th in this round's search.
    logic [IDX_W-1:0] cand_idx [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'((int'(ptr) + gi) % NUM_REQ);
        end
    endgenerate

    // Walk the candidates from last to first so the earliest candidate that
    // requests is the one left standing.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[cand_idx[i]]) begin
                idx   = cand_idx[i];
                valid = 1'b1;
            end
        end
        grant = '0;
        if (valid) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Arbitrates several requesters onto one SPI slave-select engine and
// sequences a single transfer at a time.
//   PCLK, PRESET        : clock and synchronous active-high reset
//   req_i               : per-requester level request, held until done_o
//   mode_i, div_i       : per-requester spi_mode / baud divisor slices
//   spiswai_i           : wait-in-wait, blocks new grants while high
//   tip_i               : transfer in progress from the engine
//   receive_data_i      : end-of-transfer strobe from the engine
//   grant_o             : one-hot current owner, zero when idle
//   done_o, err_o       : completion pulse to owner, timeout flag with it
//   mstr_o, spi_mode_o, BaudRateDivisor_o, send_data_o : engine config/start
// TIP_TIMEOUT must be at least 2.
module spi_xfer_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int TIP_TIMEOUT = DEF_TIP_TIMEOUT
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [MODE_W*NUM_REQ-1:0]   mode_i,
    input  logic [DIV_W*NUM_REQ-1:0]    div_i,
    input  logic                        spiswai_i,
    input  logic                        tip_i,
    input  logic                        receive_data_i,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic [NUM_REQ-1:0]          done_o,
    output logic                        err_o,
    output logic                        mstr_o,
    output logic [MODE_W-1:0]           spi_mode_o,
    output logic [DIV_W-1:0]            BaudRateDivisor_o,
    output logic                        send_data_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIP_TIMEOUT + 1);
    // The counter is cleared in START and advances once per WAIT_TIP cycle.
    // Giving up when it holds TIP_TIMEOUT-2 places the DONE cycle (done_o and
    // err_o) exactly TIP_TIMEOUT cycles after the send_data_o cycle; tip_i
    // seen on that last WAIT_TIP edge still wins over the timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIP_TIMEOUT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    sched_state_t         state_reg,    state_next;
    logic [IDX_W-1:0]     rr_ptr_reg,   rr_ptr_next;
    logic [IDX_W-1:0]     win_idx_reg,  win_idx_next;
    logic [NUM_REQ-1:0]   grant_reg,    grant_next;
    logic [MODE_W-1:0]    mode_reg,     mode_next;
    logic [DIV_W-1:0]     div_reg,      div_next;
    logic [CNT_W-1:0]     tip_cnt_reg,  tip_cnt_next;
    logic                 err_flag_reg, err_flag_next;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;

    // Per-requester configuration fields unpacked from the flat buses.
    logic [MODE_W-1:0]    mode_slice [NUM_REQ];
    logic [DIV_W-1:0]     div_slice  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign mode_slice[gi] = mode_i[MODE_W*gi +: MODE_W];
            assign div_slice[gi]  = div_i[DIV_W*gi +: DIV_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req_i),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            win_idx_reg  <= '0;
            grant_reg    <= '0;
            mode_reg     <= '0;
            div_reg      <= '0;
            tip_cnt_reg  <= '0;
            err_flag_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            win_idx_reg  <= win_idx_next;
            grant_reg    <= grant_next;
            mode_reg     <= mode_next;
            div_reg      <= div_next;
            tip_cnt_reg  <= tip_cnt_next;
            err_flag_reg <= err_flag_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        win_idx_next  = win_idx_reg;
        grant_next    = grant_reg;
        mode_next     = mode_reg;
        div_next      = div_reg;
        tip_cnt_next  = tip_cnt_reg;
        err_flag_next = err_flag_reg;

        case (state_reg)
            IDLE: begin
                // Configuration is captured only here, so later changes on
                // mode_i/div_i or req_i cannot disturb a running transfer.
                if (arb_valid && !spiswai_i) begin
                    grant_next   = arb_grant;
                    win_idx_next = arb_idx;
                    mode_next    = mode_slice[arb_idx];
                    div_next     = div_slice[arb_idx];
                    state_next   = SETUP;
                end
            end
            SETUP: begin
                state_next = START;
            end
            START: begin
                tip_cnt_next = '0;
                state_next   = WAIT_TIP;
            end
            WAIT_TIP: begin
                if (tip_i) begin
                    state_next = XFER;
                end else if (tip_cnt_reg == CNT_LAST) begin
                    err_flag_next = 1'b1;
                    state_next    = DONE;
                end else begin
                    tip_cnt_next = tip_cnt_reg + 1'b1;
                end
            end
            XFER: begin
                if (receive_data_i || !tip_i) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                grant_next    = '0;
                err_flag_next = 1'b0;
                rr_ptr_next   = (win_idx_reg == IDX_LAST) ? '0 : win_idx_reg + 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign grant_o           = grant_reg;
    assign done_o            = (state_reg == DONE) ? grant_reg : '0;
    assign err_o             = (state_reg == DONE) && err_flag_reg;
    assign mstr_o            = (state_reg != IDLE);
    assign send_data_o       = (state_reg == START);
    assign spi_mode_o        = mode_reg;
    assign BaudRateDivisor_o = div_reg;

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Self-checking bench for spi_xfer_scheduler: a table of directed
// transactions, hand-written wait-mode / reset / fairness sequences and
// randomized transactions checked against a round-robin reference model.
module tb_spi_xfer_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int TIP_TIMEOUT = 15;

    logic        PCLK;
    logic        PRESET;
    logic [3:0]  req_i;
    logic [7:0]  mode_i;
    logic [47:0] div_i;
    logic        spiswai_i;
    logic        tip_i;
    logic        receive_data_i;
    logic [3:0]  grant_o;
    logic [3:0]  done_o;
    logic        err_o;
    logic        mstr_o;
    logic [1:0]  spi_mode_o;
    logic [11:0] BaudRateDivisor_o;
    logic        send_data_o;

    int n_cmp  = 0;
    int n_fail = 0;

    spi_xfer_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .TIP_TIMEOUT (TIP_TIMEOUT)
    ) dut (
        .PCLK              (PCLK),
        .PRESET            (PRESET),
        .req_i             (req_i),
        .mode_i            (mode_i),
        .div_i             (div_i),
        .spiswai_i         (spiswai_i),
        .tip_i             (tip_i),
        .receive_data_i    (receive_data_i),
        .grant_o           (grant_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .mstr_o            (mstr_o),
        .spi_mode_o        (spi_mode_o),
        .BaudRateDivisor_o (BaudRateDivisor_o),
        .send_data_o       (send_data_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete transaction. Starts at a falling edge where the DUT is
    // idle and ends at the falling edge after done (idle again).
    // Time t counts falling edges from the one where send_data_o is seen;
    // an input driven at t is sampled t edges after the START edge.
    task automatic run_xfer(input string tag, input logic [3:0] req, input logic [7:0] mbus,
                            input logic [47:0] dbus, input int tip_d, input int end_t,
                            input bit end_rd, input bit perturb, input bit hold_req,
                            input logic [3:0] exp_grant, input logic [1:0] exp_mode,
                            input logic [11:0] exp_div, input bit exp_err);
        bit         timeout;
        int         exp_done_t;
        int         got_t;
        bit         hold_bad;
        logic [3:0] done_seen;
        logic       err_seen;
        timeout    = (tip_d >= TIP_TIMEOUT);
        exp_done_t = timeout ? TIP_TIMEOUT : end_t + 1;
        req_i = req; mode_i = mbus; div_i = dbus;
        spiswai_i = 1'b0; tip_i = 1'b0; receive_data_i = 1'b0;
        tick();
        chk({tag, ".grant"}, 48'(grant_o), 48'(exp_grant));
        chk({tag, ".mode"}, 48'(spi_mode_o), 48'(exp_mode));
        chk({tag, ".div"}, 48'(BaudRateDivisor_o), 48'(exp_div));
        chk({tag, ".setup_mstr"}, 48'(mstr_o), 48'd1);
        chk({tag, ".setup_send"}, 48'(send_data_o), 48'd0);
        tick();
        chk({tag, ".send"}, 48'(send_data_o), 48'd1);
        got_t = -1; hold_bad = 1'b0; done_seen = '0; err_seen = 1'b0;
        for (int t = 0; t < 60 && got_t < 0; t++) begin
            tip_i = (!timeout && t >= tip_d && (end_rd || t < end_t)) ? 1'b1 : 1'b0;
            receive_data_i = (!timeout && end_rd && t == end_t) ? 1'b1 : 1'b0;
            if (perturb && t == (timeout ? 5 : tip_d + 1)) begin
                mode_i    = ~mbus;
                div_i     = dbus ^ 48'h00C00C00C00C;
                spiswai_i = 1'b1;
                if (!hold_req) req_i = '0;
            end
            tick();
            if (grant_o !== exp_grant || spi_mode_o !== exp_mode ||
                BaudRateDivisor_o !== exp_div || mstr_o !== 1'b1 ||
                send_data_o !== 1'b0 || !$onehot0(grant_o))
                hold_bad = 1'b1;
            if (done_o !== 4'b0000) begin
                got_t = t + 1; done_seen = done_o; err_seen = err_o;
            end else if (err_o !== 1'b0) begin
                hold_bad = 1'b1;
            end
        end
        chk({tag, ".done_time"}, 48'(got_t), 48'(exp_done_t));
        chk({tag, ".done"}, 48'(done_seen), 48'(exp_grant));
        chk({tag, ".err"}, 48'(err_seen), 48'(exp_err));
        chk({tag, ".held"}, 48'(hold_bad), 48'd0);
        tip_i = 1'b0; receive_data_i = 1'b0; spiswai_i = 1'b0;
        req_i = hold_req ? req : 4'b0000;
        tick();
        chk({tag, ".idle_grant"}, 48'(grant_o), 48'd0);
        chk({tag, ".idle_done"}, 48'(done_o), 48'd0);
        chk({tag, ".idle_mstr"}, 48'(mstr_o), 48'd0);
        $display("xfer %s req=%b grant=%b mode=%b div=%03h done_t=%0d err=%b",
                 tag, req, exp_grant, exp_mode, exp_div, got_t, err_seen);
    endtask

    typedef struct {
        string       tag;
        logic [3:0]  req;
        logic [7:0]  mbus;
        logic [47:0] dbus;
        int          tip_d;
        int          end_t;
        bit          end_rd;
        bit          perturb;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_mode;
        logic [11:0] exp_div;
        bit          exp_err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int         m_ptr;
        int         win;
        logic [3:0] r_req;
        logic [7:0] r_mode;
        logic [47:0] r_div;
        int         r_tip;
        int         r_end;

        // Expected grants follow the round-robin pointer left by the row above.
        vecs[0] = '{"single",   4'b0001, 8'h00, 48'h000000000008,  3, 23, 1'b1, 1'b0, 4'b0001, 2'b00, 12'h008, 1'b0};
        vecs[1] = '{"timeout",  4'b0100, 8'hDB, 48'h7A1123456789, 99,  0, 1'b1, 1'b0, 4'b0100, 2'b01, 12'h123, 1'b1};
        vecs[2] = '{"tip_last", 4'b0100, 8'h36, 48'h111ABC222333, 14, 16, 1'b0, 1'b0, 4'b0100, 2'b11, 12'hABC, 1'b0};
        vecs[3] = '{"wrap",     4'b0011, 8'h72, 48'h444555666000,  1,  2, 1'b1, 1'b0, 4'b0001, 2'b10, 12'h000, 1'b0};
        vecs[4] = '{"cfg_hold", 4'b0010, 8'hA7, 48'h123456008789,  2, 12, 1'b1, 1'b1, 4'b0010, 2'b01, 12'h008, 1'b0};
        vecs[5] = '{"tip_end",  4'b1001, 8'hC6, 48'hFFF000001002,  5,  9, 1'b0, 1'b0, 4'b1000, 2'b11, 12'hFFF, 1'b0};
        vecs[6] = '{"tip_late", 4'b1111, 8'hB1, 48'h999888777555, 15, 20, 1'b1, 1'b0, 4'b0001, 2'b01, 12'h555, 1'b1};

        PRESET = 1'b1; req_i = 4'b1111; mode_i = 8'hFF; div_i = 48'hFFFFFFFFFFFF;
        spiswai_i = 1'b0; tip_i = 1'b0; receive_data_i = 1'b0;
        tick();
        tick();
        chk("rst.grant", 48'(grant_o), 48'd0);
        chk("rst.done", 48'(done_o), 48'd0);
        chk("rst.err", 48'(err_o), 48'd0);
        chk("rst.send", 48'(send_data_o), 48'd0);
        chk("rst.mstr", 48'(mstr_o), 48'd0);
        chk("rst.mode", 48'(spi_mode_o), 48'd0);
        chk("rst.div", 48'(BaudRateDivisor_o), 48'd0);
        PRESET = 1'b0; req_i = 4'b0000;

        foreach (vecs[i]) begin
            run_xfer(vecs[i].tag, vecs[i].req, vecs[i].mbus, vecs[i].dbus, vecs[i].tip_d,
                     vecs[i].end_t, vecs[i].end_rd, vecs[i].perturb, 1'b0,
                     vecs[i].exp_grant, vecs[i].exp_mode, vecs[i].exp_div, vecs[i].exp_err);
        end

        // Wait mode: requester 1 is next in line but spiswai_i holds it off.
        spiswai_i = 1'b1; req_i = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("wait.grant%0d", k), 48'(grant_o), 48'd0);
        end
        run_xfer("wait_rel", 4'b0010, 8'h04, 48'h000000020000, 2, 6, 1'b1, 1'b0, 1'b0,
                 4'b0010, 2'b01, 12'h020, 1'b0);

        // Reset during XFER with the pointer at 2: no done, pointer back to 0.
        req_i = 4'b0100; mode_i = 8'h30; div_i = 48'h0000AA000000;
        tick();
        chk("rstx.grant", 48'(grant_o), 48'b0100);
        tick();
        tip_i = 1'b1;
        tick();
        tick();
        PRESET = 1'b1;
        tick();
        chk("rstx.grant", 48'(grant_o), 48'd0);
        chk("rstx.done", 48'(done_o), 48'd0);
        chk("rstx.err", 48'(err_o), 48'd0);
        chk("rstx.send", 48'(send_data_o), 48'd0);
        chk("rstx.mstr", 48'(mstr_o), 48'd0);
        chk("rstx.mode", 48'(spi_mode_o), 48'd0);
        chk("rstx.div", 48'(BaudRateDivisor_o), 48'd0);
        PRESET = 1'b0; tip_i = 1'b0;

        // Fairness with all four requesting throughout.
        for (int k = 0; k < 5; k++) begin
            run_xfer($sformatf("fair%0d", k), 4'b1111, 8'hE4, 48'h004003002001, 2, 5, 1'b1,
                     1'b0, (k < 4), 4'(1 << (k % 4)), 2'(k % 4), 12'((k % 4) + 1), 1'b0);
        end

        // Randomized transactions against the round-robin reference model.
        m_ptr = 1;
        for (int n = 0; n < 40; n++) begin
            r_req  = 4'($urandom_range(1, 15));
            r_mode = 8'($urandom);
            r_div  = {16'($urandom), 32'($urandom)};
            r_tip  = $urandom_range(1, 17);
            r_end  = r_tip + $urandom_range(1, 8);
            win = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (win < 0 && r_req[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
            end
            run_xfer($sformatf("rnd%0d", n), r_req, r_mode, r_div, r_tip, r_end,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                     4'(1 << win), r_mode[2*win +: 2], r_div[12*win +: 12],
                     (r_tip >= TIP_TIMEOUT));
            m_ptr = (win + 1) % NUM_REQ;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_xfer_scheduler.md
SPI_XFER_SCHEDULER -- requirements
Module: spi_xfer_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one SPI slave-select engine.
REQ-002 Parameter TIP_TIMEOUT, default 15, PCLK cycles allowed between send_data_o and tip_i rising.
REQ-003 PCLK  input  1  sole clock, all state updates on rising edge.
REQ-004 PRESET  input  1  reset: synchronous, active-high.
REQ-005 req_i  input  NUM_REQ  per-requester transfer request, level, held until done_o.
REQ-006 mode_i  input  2*NUM_REQ  per-requester spi_mode, slice k = bits [2k+1:2k].
REQ-007 div_i  input  12*NUM_REQ  per-requester baud-rate divisor, slice k = bits [12k+11:12k].
REQ-008 spiswai_i  input  1  SPI wait-in-wait; blocks new grants while high.
REQ-009 tip_i  input  1  transfer-in-progress from the slave-select engine.
REQ-010 receive_data_i  input  1  one-cycle end-of-transfer strobe from the slave-select engine.
REQ-011 grant_o  output  NUM_REQ  one-hot owner of the engine, all-zero when idle.
REQ-012 done_o  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-013 err_o  output  1  one-cycle pulse with done_o when the transfer timed out.
REQ-014 mstr_o, spi_mode_o[1:0], BaudRateDivisor_o[11:0], send_data_o  outputs  engine configuration and start strobe.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, START, WAIT_TIP, XFER, DONE.
REQ-016 IDLE: if any req_i bit high and spiswai_i low, the scheduler SHALL pick a winner round-robin from rr_ptr, register grant_o, spi_mode_o and BaudRateDivisor_o from the winner's slices, and go to SETUP.
REQ-017 Round-robin SHALL search upward from rr_ptr, wrapping from NUM_REQ-1 to 0; rr_ptr SHALL become winner+1 (mod NUM_REQ) in DONE.
REQ-018 SETUP SHALL last exactly one cycle with mstr_o=1 and configuration stable, then go to START.
REQ-019 START SHALL assert send_data_o for exactly one cycle, clear the timeout counter, and go to WAIT_TIP.
REQ-020 WAIT_TIP: tip_i high SHALL move to XFER; if the counter reaches TIP_TIMEOUT with tip_i low, the FSM SHALL go to DONE with error flagged.
REQ-021 XFER: receive_data_i high, or tip_i low, SHALL move to DONE.
REQ-022 DONE SHALL pulse done_o on the granted bit (plus err_o if flagged) for one cycle, clear grant_o, mstr_o and error flag, and return to IDLE.
REQ-023 Latency: req_i sampled high in IDLE at edge N SHALL give grant_o at N+1, send_data_o at N+2 and done_o one cycle after the terminating event.
REQ-024 Configuration outputs SHALL stay constant from SETUP through DONE regardless of mode_i/div_i changes.
REQ-025 A req_i dropped mid-transfer SHALL NOT abort it; done_o still pulses.
REQ-026 spiswai_i rising mid-transfer SHALL NOT affect the current transfer; it blocks only the next IDLE decision.
REQ-027 A divisor of 0 SHALL be forwarded unchanged; validation belongs to the engine.
REQ-028 The scheduler SHALL never assert more than one grant_o bit, and send_data_o only in START.

Reset
REQ-029 With PRESET high at a PCLK edge, FSM=IDLE, rr_ptr=0, grant_o=0, done_o=0, err_o=0, send_data_o=0, mstr_o=0, spi_mode_o=0, BaudRateDivisor_o=0, counter=0.
REQ-030 PRESET during any state SHALL abort the transfer without emitting done_o.

Structure
REQ-031 Package spi_sched_pkg SHALL hold the state enumeration, the default NUM_REQ and TIP_TIMEOUT values and the 12-bit divisor width constant.
REQ-032 Winner selection SHALL be a sub-module rr_arbiter (req vector and pointer in, one-hot grant and index out, combinational).

Verification
REQ-033 Single request: req_i=0001, mode 2'b00, div 8, tip_i rises 3 cycles after send_data_o, receive_data_i 20 cycles later -> grant_o=0001, BaudRateDivisor_o=8, done_o=0001 one cycle after receive_data_i, err_o=0.
REQ-034 Fairness: req_i=1111 held throughout -> grants in order 0001,0010,0100,1000,0001.
REQ-035 Timeout: req_i=0100, tip_i held low -> done_o=0100 and err_o=1 together, 15 cycles after send_data_o.
REQ-036 Wait mode: spiswai_i=1 with req_i=0010 -> grant_o stays 0; spiswai_i drops -> grant_o=0010 next cycle.
REQ-037 Reset mid-XFER: PRESET=1 one cycle -> all outputs zero next edge, no done_o, next grant starts from requester 0.
REQ-038 Config hold: change div_i of the winner from 8 to 4 during XFER -> BaudRateDivisor_o stays 8 until DONE.
